e_branch_resolve: RTL

Parametrised execute-stage branch resolution unit with integrated 2-bit branch history table (BHT). It resolves jal/jalr/conditional branches from EX-stage operands, registers a one-cycle redirect on misprediction, emits branch-target-cache write data, and trains a per-PC saturating counter table. It also serves taken/not-taken predictions to fetch and keeps branch and mispredict counters. After every reset it self-initialises the table before accepting instructions.

---
 rtl/br_pkg.sv | 61 ++++++
 rtl/bht_2bit.sv | 73 +++++++
 rtl/e_branch_resolve.sv | 130 +++++++++++++
 3 files changed

// File: rtl/br_pkg.sv
// Shared encodings for the execute-stage branch resolution unit:
// jump/branch codes, 2-bit counter values, table FSM states and helpers.
package br_pkg;

    // ex_jump_code encodings
    localparam logic [1:0] JC_NONE   = 2'b00;
    localparam logic [1:0] JC_BRANCH = 2'b01;
    localparam logic [1:0] JC_JAL    = 2'b10;
    localparam logic [1:0] JC_JALR   = 2'b11;

    // ex_branch_code encodings (funct3); any other code is never taken
    localparam logic [2:0] BC_EQ  = 3'b000;
    localparam logic [2:0] BC_NE  = 3'b001;
    localparam logic [2:0] BC_LT  = 3'b100;
    localparam logic [2:0] BC_GE  = 3'b101;
    localparam logic [2:0] BC_LTU = 3'b110;
    localparam logic [2:0] BC_GEU = 3'b111;

    // 2-bit saturating counter values; bit 1 is the taken prediction
    localparam logic [1:0] BHT_SNT = 2'd0;
    localparam logic [1:0] BHT_WNT = 2'd1;
    localparam logic [1:0] BHT_WT  = 2'd2;
    localparam logic [1:0] BHT_ST  = 2'd3;

    // Table FSM: INIT sweeps every entry to weakly-not-taken, RUN serves traffic
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bht_state_e;

    // Branch condition on full 32-bit operands
    function automatic logic branch_cond(input logic [2:0] code,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
        logic r;
        r = 1'b0;
        case (code)
            BC_EQ:   r = (a == b);
            BC_NE:   r = (a != b);
            BC_LT:   r = ($signed(a) <  $signed(b));
            BC_GE:   r = ($signed(a) >= $signed(b));
            BC_LTU:  r = (a <  b);
            BC_GEU:  r = (a >= b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Saturating step of a 2-bit counter
    function automatic logic [1:0] sat_update(input logic [1:0] cur, input logic inc);
        logic [1:0] r;
        r = cur;
        if (inc) begin
            if (cur != BHT_ST) r = cur + 2'd1;
        end else begin
            if (cur != BHT_SNT) r = cur - 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// 2-bit branch history table: counter array, self-initialising INIT/RUN FSM,
// combinational prediction read port and a single saturating update port.
// The array itself has no reset; INIT writes every entry after each reset.
module bht_2bit
    import br_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_set_strong,
    input  logic             upd_taken,
    output logic             state_dbg
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [1:0]       bht_q [DEPTH];
    bht_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [1:0]       wr_val;

    // FSM register and init sweep index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state and the single write port: init sweep or training update
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        wr_idx  = upd_idx;
        wr_val  = BHT_WNT;
        case (state_q)
            ST_INIT: begin
                wr_en  = 1'b1;
                wr_idx = idx_q;
                wr_val = BHT_WNT;
                idx_d  = idx_q + 1'b1;
                if (idx_q == '1) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (upd_en) begin
                    wr_en  = 1'b1;
                    wr_val = upd_set_strong ? BHT_ST : sat_update(bht_q[upd_idx], upd_taken);
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Counter array write; reads in the same cycle see the old value
    always_ff @(posedge clk) begin
        if (wr_en) bht_q[wr_idx] <= wr_val;
    end

    assign rd_taken  = (state_q == ST_RUN) & bht_q[rd_idx][1];
    assign state_dbg = state_q;

endmodule

// File: rtl/e_branch_resolve.sv
// Execute-stage branch resolution: computes the real next PC for jal/jalr and
// conditional branches, raises a registered one-cycle redirect on mispredict,
// emits branch-target-cache write data, trains the BHT and counts events.
// The EX slot right after a redirect is wrong-path and is ignored.
module e_branch_resolve
    import br_pkg::*;
#(
    parameter int PC_W      = 13,
    parameter int BTB_IDX_W = 11,
    parameter int BHT_IDX_W = 6,
    parameter int CNT_W     = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ex_valid,
    input  logic [PC_W-1:0]             ex_pc,
    input  logic [PC_W-1:0]             ex_pc_predicted,
    input  logic [31:0]                 ex_imm,
    input  logic [31:0]                 ex_rs1,
    input  logic [31:0]                 ex_rs2,
    input  logic [1:0]                  ex_jump_code,
    input  logic [2:0]                  ex_branch_code,
    input  logic                        ex_cannot_calcpc,
    input  logic [PC_W-1:0]             f_pc,
    output logic                        f_pred_taken,
    output logic                        redirect_valid,
    output logic [PC_W-1:0]             redirect_pc,
    output logic                        btb_wen,
    output logic [BTB_IDX_W-1:0]        btb_w_addr,
    output logic [2*PC_W-BTB_IDX_W:0]   btb_w_data,
    output logic                        init_busy,
    output logic [CNT_W-1:0]            branch_count,
    output logic [CNT_W-1:0]            mispredict_count
);

    localparam int BTB_DW = 1 + 2 * PC_W - BTB_IDX_W;

    logic                 redirect_valid_q, redirect_valid_d;
    logic [PC_W-1:0]      redirect_pc_q, redirect_pc_d;
    logic                 btb_wen_q, btb_wen_d;
    logic [BTB_IDX_W-1:0] btb_w_addr_q, btb_w_addr_d;
    logic [BTB_DW-1:0]    btb_w_data_q, btb_w_data_d;
    logic [CNT_W-1:0]     branch_count_q, branch_count_d;
    logic [CNT_W-1:0]     mispredict_count_q, mispredict_count_d;

    logic [PC_W-1:0]      jump_base;
    logic [PC_W-1:0]      jump_pc;
    logic [PC_W-1:0]      next_pc;
    logic                 cond;
    logic                 taken;
    logic                 acc;
    logic                 is_cti;
    logic                 mispredict;
    logic                 bht_state;

    // Operand bits outside the word-address window do not affect the result
    logic unused_ok;
    assign unused_ok = ^{ex_imm[31:PC_W+2], ex_imm[1:0], f_pc[PC_W-1:BHT_IDX_W]};

    // Target, condition, acceptance and next register values
    always_comb begin
        jump_base          = (ex_jump_code == JC_JALR) ? ex_rs1[PC_W+1:2] : ex_pc;
        jump_pc            = ex_imm[PC_W+1:2] + jump_base;
        cond               = branch_cond(ex_branch_code, ex_rs1, ex_rs2);
        taken              = ((ex_jump_code == JC_BRANCH) & cond) | ex_jump_code[1];
        next_pc            = taken ? jump_pc : (ex_pc + PC_W'(1));
        acc                = ex_valid & ~init_busy & ~redirect_valid_q;
        is_cti             = acc & (ex_jump_code != JC_NONE);
        mispredict         = acc & ex_cannot_calcpc & (next_pc != ex_pc_predicted);

        redirect_valid_d   = mispredict;
        redirect_pc_d      = mispredict ? next_pc : redirect_pc_q;
        btb_wen_d          = is_cti;
        btb_w_addr_d       = btb_w_addr_q;
        btb_w_data_d       = btb_w_data_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (is_cti) begin
            btb_w_addr_d   = ex_pc[BTB_IDX_W-1:0];
            btb_w_data_d   = {1'b1, ex_pc[PC_W-1:BTB_IDX_W], jump_pc};
            branch_count_d = branch_count_q + CNT_W'(1);
        end
        if (mispredict) mispredict_count_d = mispredict_count_q + CNT_W'(1);
    end

    // Output and performance counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid_q   <= 1'b0;
            redirect_pc_q      <= '0;
            btb_wen_q          <= 1'b0;
            btb_w_addr_q       <= '0;
            btb_w_data_q       <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            redirect_valid_q   <= redirect_valid_d;
            redirect_pc_q      <= redirect_pc_d;
            btb_wen_q          <= btb_wen_d;
            btb_w_addr_q       <= btb_w_addr_d;
            btb_w_data_q       <= btb_w_data_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    bht_2bit #(
        .IDX_W(BHT_IDX_W)
    ) u_bht (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_idx        (f_pc[BHT_IDX_W-1:0]),
        .rd_taken      (f_pred_taken),
        .upd_en        (is_cti),
        .upd_idx       (ex_pc[BHT_IDX_W-1:0]),
        .upd_set_strong(ex_jump_code[1]),
        .upd_taken     (taken),
        .state_dbg     (bht_state)
    );

    assign init_busy        = (bht_state == 1'(ST_INIT));
    assign redirect_valid   = redirect_valid_q;
    assign redirect_pc      = redirect_pc_q;
    assign btb_wen          = btb_wen_q;
    assign btb_w_addr       = btb_w_addr_q;
    assign btb_w_data       = btb_w_data_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule
